// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the bit-pattern detector: accepts words over
// valid/ready and shifts them out one bit per clock on `a`, idling at IDLE_BIT.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BIT  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             a,
  output logic             busy,
  output logic             done
);

  localparam int   CW     = $clog2(WIDTH);
  localparam logic IDLE_L = (IDLE_BIT != 0);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-2:0] sr_q;
  logic             a_q;
  logic             busy_q;
  logic             done_q;

  logic             first_d;
  logic [WIDTH-2:0] rest_d;
  logic             accept;

  // Remaining bits are stored in send order so the next bit is always the MSB.
  always_comb begin
    first_d = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
    rest_d  = '0;
    for (int unsigned j = 0; j < WIDTH - 1; j++) begin
      rest_d[WIDTH-2-j] = (MSB_FIRST != 0) ? load_data[WIDTH-2-j] : load_data[j+1];
    end
  end

  assign load_ready = !hold && ((state_q == IDLE) || (cnt_q == '0));
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      a_q     <= IDLE_L;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!hold) begin
        if (state_q == SHIFT && cnt_q == '0) begin
          done_q <= 1'b1;
        end
        if (accept) begin
          a_q     <= first_d;
          sr_q    <= rest_d;
          cnt_q   <= CW'(WIDTH - 1);
          state_q <= SHIFT;
          busy_q  <= 1'b1;
        end else if (state_q == SHIFT) begin
          if (cnt_q != '0) begin
            a_q   <= sr_q[WIDTH-2];
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            a_q     <= IDLE_L;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      end
    end
  end

  assign a    = a_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: accepted words are expanded into an
// expected bit stream, and a monitor checks a/busy/done every cycle.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready;
  logic       hold = 1'b0;
  logic       a, busy, done;

  logic       lv1 = 1'b0;
  logic [7:0] ld1 = '0;
  logic       lr1, a1, busy1, done1;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .hold(hold), .a(a), .busy(busy), .done(done)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .load_valid(lv1), .load_data(ld1),
    .load_ready(lr1), .hold(1'b0), .a(a1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } ent_t;

  ent_t sbq[$];
  logic on_a     = 1'b0;
  logic cur_bit  = 1'b0;
  logic cur_last = 1'b0;
  logic exp_done = 1'b0;
  int   n_chk    = 0;
  int   n_pass   = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endfunction

  // Reference model: a word is WIDTH queued bits; each unheld edge moves the next one onto `a`.
  initial begin
    logic h, rn;
    ent_t e;
    forever begin
      @(posedge clk);
      h  = hold;
      rn = reset_n;
      #1;
      if (!rn) begin
        on_a = 1'b0;
        exp_done = 1'b0;
        sbq.delete();
      end else if (!h) begin
        exp_done = on_a && cur_last;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          on_a = 1'b1;
          cur_bit = e.b;
          cur_last = e.last;
        end else begin
          on_a = 1'b0;
        end
      end else begin
        exp_done = 1'b0;
      end
      chk("a", a, on_a ? cur_bit : 1'b1);
      chk("busy", busy, on_a);
      chk("done", done, exp_done);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic h, output logic acc);
    @(negedge clk);
    load_valid = v;
    load_data  = d;
    hold       = h;
    #1;
    chk("load_ready", load_ready, !h && (!on_a || cur_last));
    acc = v && load_ready;
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        sbq.push_back('{b: (d >> (7 - i)) & 8'd1, last: (i == 7)});
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic send(input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) cyc(1'b1, d, 1'b0, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [7:0] lsb_word;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(10);

    send(8'h5A);
    idle(10);

    send(8'hF0);
    send(8'h0F);
    idle(10);

    send(8'hA5);
    cyc(1'b0, 8'h00, 1'b0, acc);
    cyc(1'b0, 8'h00, 1'b0, acc);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, acc);
    idle(12);

    send(8'hFF);
    idle(3);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    on_a = 1'b0;
    exp_done = 1'b0;
    sbq.delete();
    #1;
    chk("rst_a", a, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(8'h00);
    idle(12);

    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 4) == 0), acc);
    end
    idle(12);

    // LSB-first instance with idle level 0
    lsb_word = 8'h01;
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = lsb_word;
    #1;
    chk("lsb_ready", lr1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("lsb_a", a1, (lsb_word >> i) & 8'd1);
      chk("lsb_busy", busy1, 1'b1);
      if (i == 0) lv1 = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("lsb_idle_a", a1, 1'b0);
    chk("lsb_done", done1, 1'b1);
    chk("lsb_busy_end", busy1, 1'b0);
    @(posedge clk);
    #1;
    chk("lsb_idle_a2", a1, 1'b0);
    chk("lsb_done2", done1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Upstream stage of the bit-pattern detector: accepts parallel words over a valid/ready handshake and drives them one bit per clock onto the detector's single-bit input `a`. When no word is in flight, `a` is held at a configurable idle level so the detector sits in its reset state without seeing false patterns. Words can be streamed back-to-back with no gap. A `hold` input freezes the stream mid-word.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- `IDLE_BIT`, 1: level driven on `a` when not shifting.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  upstream has a word on `load_data`.
- `load_data`  in  WIDTH  word to serialise.
- `load_ready`  out  1  block accepts `load_data` this cycle.
- `hold`  in  1  freeze shifting and acceptance while high.
- `a`  out  1  serial bit to detector; registered.
- `busy`  out  1  a word bit is currently on `a`; registered.
- `done`  out  1  one-cycle pulse after the last bit of a word leaves `a`; registered.

## Operation
- States: IDLE and SHIFT. Internal shift register (WIDTH-1 bits) and remaining-bit counter `cnt` (clog2(WIDTH) bits).
- Reset (`reset_n` low, asynchronous): state IDLE, `a`=IDLE_BIT, `busy`=0, `done`=0, shift register 0, `cnt`=0. `load_ready` then reads 1 if `hold`=0.
- `load_ready` is combinational: `!hold && (state==IDLE || (state==SHIFT && cnt==0))`.
- Accept = `load_valid && load_ready` at a rising edge. On accept: `a` <= first bit (per MSB_FIRST), shift register <= remaining WIDTH-1 bits in send order, `cnt` <= WIDTH-1, state SHIFT, `busy` <= 1.
- SHIFT, `hold`=0, `cnt`>0: `a` <= next bit, shift register advances, `cnt` decrements.
- SHIFT, `hold`=0, `cnt`==0 (last bit on `a`): `done` <= 1. If accept also occurs, load the new word as above (back-to-back, no idle cycle). Otherwise `a` <= IDLE_BIT, `busy` <= 0, state IDLE.
- `done` is 0 on every other edge.
- `hold`=1: state, `a`, `busy`, `cnt`, shift register unchanged; `done` <= 0; no accept.
- IDLE with no accept: `a` stays IDLE_BIT.
- `load_data` is sampled only at the accepting edge; later changes have no effect.

## Timing
- Accept at edge k: first bit on `a` from edge k through edge k+1; bit i (0-based in send order) valid between edges k+i and k+i+1, absent `hold`.
- Word occupies `a` for exactly WIDTH cycles without `hold`; each `hold` cycle adds one.
- Last bit leaves `a` at edge k+WIDTH; `done` high from edge k+WIDTH to k+WIDTH+1.
- Continuous streaming: one word accepted every WIDTH cycles; `busy` stays 1; `done` pulses every WIDTH cycles.
- `reset_n` asserted mid-word aborts the word immediately (asynchronous). No `done` is issued for the aborted word. The first edge after release may accept.

## Test plan
- Reset/idle: hold `reset_n`=0 then release with `load_valid`=0 for 10 cycles -> `a`=1, `busy`=0, `done`=0, `load_ready`=1 throughout.
- Single word, MSB_FIRST=1: accept 0x5A -> `a` = 0,1,0,1,1,0,1,0 on the 8 following cycles, then 1. `done` is high only in the cycle after bit 7, and `busy` is high for exactly 8 cycles.
- Back-to-back: `load_valid` held high with 0xF0 then 0x0F -> 16 contiguous bits 1111000000001111 with no idle gap. `load_ready` is high only on the cycles where the last bit of 0xF0 and the last bit of 0x0F are on `a`. `done` pulses twice, 8 cycles apart.
- Hold mid-word: accept 0xA5, assert `hold` for 3 cycles after bit 2 -> bit 2 persists for 4 cycles, `load_ready`=0 and `done`=0 during `hold`, and the remaining bits resume unchanged. Total busy duration is 11 cycles.
- Reset mid-word: accept 0xFF, drop `reset_n` after bit 3 -> `a`=1, `busy`=0 with no clock edge, and no `done`. After release, accept 0x00 -> eight 0s.
- LSB-first (MSB_FIRST=0, IDLE_BIT=0): accept 0x01 -> `a` = 1,0,0,0,0,0,0,0 then 0 while idle.
